// File: rtl/core_pkg.sv
// Shared register-index types and constants for the core pipeline.
package core_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  // x0 is hardwired to zero and is never tracked by the scoreboard
  function automatic logic idx_nonzero(input reg_idx_t idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/core_sb_counter.sv
// Per-register in-flight write counter for the ID scoreboard.
// Saturates at MAX_INFLIGHT, never underflows, and treats a same-cycle
// increment and decrement as no change.
module core_sb_counter
  import core_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_busy,
  output logic             o_full
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] r_cnt;
  logic             w_busy;
  logic             w_full;

  assign w_busy = (r_cnt != '0);
  assign w_full = (r_cnt == LP_MAX);

  // Count outstanding writes; collisions cancel, limits hold instead of wrapping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !w_full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc && w_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // A writeback for a register with nothing in flight is a pipeline protocol error
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      a_no_underflow: assert (!(i_dec && !w_busy));
    end
  end

  assign o_cnt  = r_cnt;
  assign o_busy = w_busy;
  assign o_full = w_full;

endmodule

// File: rtl/core_id_scoreboard.sv
// ID-stage register-write scoreboard and issue interlock.
// Tracks in-flight writes to x1..x31 from issue to writeback, stalls ID on
// RAW hazards and on a full per-register WAW counter, and counts stall cycles.
// Build option: CORE_SB_WB_BYPASS_EN -- write-through register file; a RAW
// dependency on the last in-flight write is released in its WB cycle.
module core_id_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic [4:0]  i_id_rd,
  input  logic        i_id_reg_write,
  input  logic        i_ex_ready,
  input  logic        i_flush,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_wb_reg_write,
  output logic        o_issue,
  output logic        o_id_stall,
  output logic [31:0] o_busy_map,
  output logic [31:0] o_stall_cycles
);

  logic [CNT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_full;

  logic w_inc;
  logic w_dec;
  logic w_byp1;
  logic w_byp2;
  logic w_raw1;
  logic w_raw2;
  logic w_waw_full;
  logic w_hazard;
  logic w_issue;
  logic w_stall;

  logic [31:0] r_stall_cycles;

  // x0 has no counter; its slot reads as permanently idle
  assign w_cnt[0]  = '0;
  assign w_busy[0] = 1'b0;
  assign w_full[0] = 1'b0;

  for (genvar n = 1; n < NUM_REGS; n++) begin : g_cnt
    core_sb_counter #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W)
    ) u_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (w_inc && (i_id_rd == reg_idx_t'(n))),
      .i_dec   (w_dec && (i_wb_rd == reg_idx_t'(n))),
      .o_cnt   (w_cnt[n]),
      .o_busy  (w_busy[n]),
      .o_full  (w_full[n])
    );
  end

  // Hazard detection against registered counter state, then issue/stall decision
  always_comb begin
    w_byp1 = 1'b0;
    w_byp2 = 1'b0;
`ifdef CORE_SB_WB_BYPASS_EN
    w_byp1 = i_wb_reg_write && (i_wb_rd == i_id_rs1) && (w_cnt[i_id_rs1] == CNT_W'(1));
    w_byp2 = i_wb_reg_write && (i_wb_rd == i_id_rs2) && (w_cnt[i_id_rs2] == CNT_W'(1));
`endif
    w_raw1     = i_id_rs1_used && idx_nonzero(i_id_rs1) && (w_cnt[i_id_rs1] != '0) && !w_byp1;
    w_raw2     = i_id_rs2_used && idx_nonzero(i_id_rs2) && (w_cnt[i_id_rs2] != '0) && !w_byp2;
    w_waw_full = i_id_reg_write && idx_nonzero(i_id_rd) && w_full[i_id_rd];
    w_hazard   = w_raw1 || w_raw2 || w_waw_full;
    w_stall    = i_id_valid && !i_flush && (w_hazard || !i_ex_ready);
    w_issue    = i_id_valid && !i_flush && !w_hazard && i_ex_ready;
    w_inc      = w_issue && i_id_reg_write && idx_nonzero(i_id_rd);
    w_dec      = i_wb_reg_write && idx_nonzero(i_wb_rd);
  end

  // Saturating count of ID stall cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_issue        = w_issue;
  assign o_id_stall     = w_stall;
  assign o_busy_map     = w_busy;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_core_id_scoreboard.sv
// Directed self-checking bench for core_id_scoreboard.
module tb_core_id_scoreboard;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_id_valid;
  logic [4:0]  i_id_rs1;
  logic [4:0]  i_id_rs2;
  logic        i_id_rs1_used;
  logic        i_id_rs2_used;
  logic [4:0]  i_id_rd;
  logic        i_id_reg_write;
  logic        i_ex_ready;
  logic        i_flush;
  logic [4:0]  i_wb_rd;
  logic        i_wb_reg_write;
  logic        o_issue;
  logic        o_id_stall;
  logic [31:0] o_busy_map;
  logic [31:0] o_stall_cycles;

  int          checks    = 0;
  int          failures  = 0;
  logic [31:0] exp_stalls = '0;

  always #5 i_clk = ~i_clk;

  core_id_scoreboard #(
    .MAX_INFLIGHT (3),
    .CNT_W        (2)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_id_valid     (i_id_valid),
    .i_id_rs1       (i_id_rs1),
    .i_id_rs2       (i_id_rs2),
    .i_id_rs1_used  (i_id_rs1_used),
    .i_id_rs2_used  (i_id_rs2_used),
    .i_id_rd        (i_id_rd),
    .i_id_reg_write (i_id_reg_write),
    .i_ex_ready     (i_ex_ready),
    .i_flush        (i_flush),
    .i_wb_rd        (i_wb_rd),
    .i_wb_reg_write (i_wb_reg_write),
    .o_issue        (o_issue),
    .o_id_stall     (o_id_stall),
    .o_busy_map     (o_busy_map),
    .o_stall_cycles (o_stall_cycles)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_id_valid     = 1'b0;
    i_id_rs1       = '0;
    i_id_rs2       = '0;
    i_id_rs1_used  = 1'b0;
    i_id_rs2_used  = 1'b0;
    i_id_rd        = '0;
    i_id_reg_write = 1'b0;
    i_ex_ready     = 1'b1;
    i_flush        = 1'b0;
    i_wb_rd        = '0;
    i_wb_reg_write = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic rw);
    i_id_valid     = 1'b1;
    i_id_rs1       = rs1;
    i_id_rs1_used  = u1;
    i_id_rs2       = rs2;
    i_id_rs2_used  = u2;
    i_id_rd        = rd;
    i_id_reg_write = rw;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic we);
    i_wb_rd        = rd;
    i_wb_reg_write = we;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_busy_map !== 32'h0) begin failures++; $display("FAIL reset_busy: got %h expected %h", o_busy_map, 32'h0); end
    checks++; if (o_stall_cycles !== 32'h0) begin failures++; $display("FAIL reset_stalls: got %0d expected 0", o_stall_cycles); end
    checks++; if (o_issue !== 1'b0 || o_id_stall !== 1'b0) begin failures++; $display("FAIL reset_comb: issue=%b stall=%b expected 0 0", o_issue, o_id_stall); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_raw();
    // ADD x5, x1, x2
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);
    #1;
    checks++; if (o_issue !== 1'b1 || o_id_stall !== 1'b0) begin failures++; $display("FAIL raw_first_issue: issue=%b stall=%b expected 1 0", o_issue, o_id_stall); end
    tick();
    // ADD x6, x5, x0
    set_id(5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1);
    #1;
    checks++; if (o_id_stall !== 1'b1 || o_issue !== 1'b0) begin failures++; $display("FAIL raw_stall_c1: issue=%b stall=%b expected 0 1", o_issue, o_id_stall); end
    checks++; if (o_busy_map !== 32'h0000_0020) begin failures++; $display("FAIL raw_busy: got %h expected %h", o_busy_map, 32'h20); end
    tick(); exp_stalls++;
    checks++; if (o_id_stall !== 1'b1 || o_issue !== 1'b0) begin failures++; $display("FAIL raw_stall_c2: issue=%b stall=%b expected 0 1", o_issue, o_id_stall); end
    tick(); exp_stalls++;
    set_wb(5'd5, 1'b1);
    #1;
`ifdef CORE_SB_WB_BYPASS_EN
    checks++; if (o_issue !== 1'b1 || o_id_stall !== 1'b0) begin failures++; $display("FAIL raw_wb_cycle: issue=%b stall=%b expected 1 0", o_issue, o_id_stall); end
    tick();
    set_wb(5'd0, 1'b0);
    i_id_valid = 1'b0;
`else
    checks++; if (o_issue !== 1'b0 || o_id_stall !== 1'b1) begin failures++; $display("FAIL raw_wb_cycle: issue=%b stall=%b expected 0 1", o_issue, o_id_stall); end
    tick(); exp_stalls++;
    set_wb(5'd0, 1'b0);
    #1;
    checks++; if (o_issue !== 1'b1 || o_id_stall !== 1'b0) begin failures++; $display("FAIL raw_after_wb: issue=%b stall=%b expected 1 0", o_issue, o_id_stall); end
    tick();
    i_id_valid = 1'b0;
`endif
    #1;
    checks++; if (o_busy_map !== 32'h0000_0040) begin failures++; $display("FAIL raw_busy_x6: got %h expected %h", o_busy_map, 32'h40); end
    set_wb(5'd6, 1'b1);
    tick();
    set_wb(5'd0, 1'b0);
    #1;
    checks++; if (o_busy_map !== 32'h0) begin failures++; $display("FAIL raw_drain: got %h expected %h", o_busy_map, 32'h0); end
  endtask

  task automatic test_waw();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (o_issue !== 1'b1) begin failures++; $display("FAIL waw_issue_%0d: got %b expected 1", k, o_issue); end
      tick();
    end
    #1;
    checks++; if (o_id_stall !== 1'b1 || o_issue !== 1'b0) begin failures++; $display("FAIL waw_full_stall: issue=%b stall=%b expected 0 1", o_issue, o_id_stall); end
    checks++; if (o_busy_map !== 32'h0000_0080) begin failures++; $display("FAIL waw_busy: got %h expected %h", o_busy_map, 32'h80); end
    tick(); exp_stalls++;
    checks++; if (o_id_stall !== 1'b1) begin failures++; $display("FAIL waw_hold: got %b expected 1", o_id_stall); end
    tick(); exp_stalls++;
    // WB x7 drops the count from 3 to 2 only at the next edge
    set_wb(5'd7, 1'b1);
    #1;
    checks++; if (o_id_stall !== 1'b1) begin failures++; $display("FAIL waw_wb_cycle: got %b expected 1", o_id_stall); end
    tick(); exp_stalls++;
    set_wb(5'd0, 1'b0);
    #1;
    checks++; if (o_issue !== 1'b1 || o_id_stall !== 1'b0) begin failures++; $display("FAIL waw_fourth_issue: issue=%b stall=%b expected 1 0", o_issue, o_id_stall); end
    tick();
    // count is back at 3: exactly three writebacks clear it
    i_id_valid = 1'b0;
    set_wb(5'd7, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_busy_map[7] !== (k < 2)) begin failures++; $display("FAIL waw_drain_%0d: got %b expected %b", k, o_busy_map[7], (k < 2)); end
    end
    set_wb(5'd0, 1'b0);
  endtask

  task automatic test_collision();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    #1;
    checks++; if (o_issue !== 1'b1) begin failures++; $display("FAIL coll_first: got %b expected 1", o_issue); end
    tick();
    set_wb(5'd9, 1'b1);
    #1;
    checks++; if (o_issue !== 1'b1 || o_id_stall !== 1'b0) begin failures++; $display("FAIL coll_issue: issue=%b stall=%b expected 1 0", o_issue, o_id_stall); end
    tick();
    i_id_valid = 1'b0;
    set_wb(5'd0, 1'b0);
    #1;
    checks++; if (o_busy_map !== 32'h0000_0200) begin failures++; $display("FAIL coll_busy: got %h expected %h", o_busy_map, 32'h200); end
    set_wb(5'd9, 1'b1);
    tick();
    set_wb(5'd0, 1'b0);
    #1;
    checks++; if (o_busy_map !== 32'h0) begin failures++; $display("FAIL coll_drain: got %h expected %h", o_busy_map, 32'h0); end
  endtask

  task automatic test_x0();
    set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
    set_wb(5'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (o_issue !== 1'b1 || o_id_stall !== 1'b0) begin failures++; $display("FAIL x0_issue_%0d: issue=%b stall=%b expected 1 0", k, o_issue, o_id_stall); end
      checks++; if (o_busy_map !== 32'h0) begin failures++; $display("FAIL x0_busy_%0d: got %h expected %h", k, o_busy_map, 32'h0); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
    #1;
    checks++; if (o_issue !== 1'b1) begin failures++; $display("FAIL flush_setup: got %b expected 1", o_issue); end
    tick();
    set_id(5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);
    #1;
    checks++; if (o_id_stall !== 1'b1) begin failures++; $display("FAIL flush_raw: got %b expected 1", o_id_stall); end
    tick(); exp_stalls++;
    i_flush = 1'b1;
    #1;
    checks++; if (o_issue !== 1'b0 || o_id_stall !== 1'b0) begin failures++; $display("FAIL flush_kill: issue=%b stall=%b expected 0 0", o_issue, o_id_stall); end
    tick();
    checks++; if (o_busy_map !== 32'h0000_0400) begin failures++; $display("FAIL flush_counters: got %h expected %h", o_busy_map, 32'h400); end
    // WB still retires while ID is being flushed
    set_wb(5'd10, 1'b1);
    #1;
    checks++; if (o_issue !== 1'b0 || o_id_stall !== 1'b0) begin failures++; $display("FAIL flush_wb_kill: issue=%b stall=%b expected 0 0", o_issue, o_id_stall); end
    tick();
    idle_inputs();
    #1;
    checks++; if (o_busy_map !== 32'h0) begin failures++; $display("FAIL flush_wb_applied: got %h expected %h", o_busy_map, 32'h0); end
    checks++; if (o_stall_cycles !== exp_stalls) begin failures++; $display("FAIL flush_stall_count: got %0d expected %0d", o_stall_cycles, exp_stalls); end
  endtask

  task automatic test_ex_ready();
    i_ex_ready = 1'b0;
    #1;
    checks++; if (o_id_stall !== 1'b0 || o_issue !== 1'b0) begin failures++; $display("FAIL exr_idle: issue=%b stall=%b expected 0 0", o_issue, o_id_stall); end
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
    #1;
    checks++; if (o_id_stall !== 1'b1 || o_issue !== 1'b0) begin failures++; $display("FAIL exr_stall: issue=%b stall=%b expected 0 1", o_issue, o_id_stall); end
    tick(); exp_stalls++;
    idle_inputs();
    #1;
    checks++; if (o_busy_map !== 32'h0) begin failures++; $display("FAIL exr_no_inc: got %h expected %h", o_busy_map, 32'h0); end
    checks++; if (o_stall_cycles !== exp_stalls) begin failures++; $display("FAIL exr_stall_count: got %0d expected %0d", o_stall_cycles, exp_stalls); end
  endtask

  task automatic test_mid_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    tick();
    i_ex_ready = 1'b0;
    tick(); exp_stalls++;
    idle_inputs();
    #1;
    checks++; if (o_busy_map !== 32'h0000_0020) begin failures++; $display("FAIL mrst_pre_busy: got %h expected %h", o_busy_map, 32'h20); end
    checks++; if (o_stall_cycles !== exp_stalls) begin failures++; $display("FAIL mrst_pre_stalls: got %0d expected %0d", o_stall_cycles, exp_stalls); end
    i_rst_n = 1'b0;
    #1;
    exp_stalls = '0;
    checks++; if (o_busy_map !== 32'h0) begin failures++; $display("FAIL mrst_busy: got %h expected %h", o_busy_map, 32'h0); end
    checks++; if (o_stall_cycles !== 32'h0) begin failures++; $display("FAIL mrst_stalls: got %0d expected 0", o_stall_cycles); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    // x5 must no longer be considered in flight
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (o_issue !== 1'b1 || o_id_stall !== 1'b0) begin failures++; $display("FAIL mrst_x5_free: issue=%b stall=%b expected 1 0", o_issue, o_id_stall); end
    tick();
    idle_inputs();
    #1;
    checks++; if (o_stall_cycles !== exp_stalls) begin failures++; $display("FAIL mrst_post_stalls: got %0d expected %0d", o_stall_cycles, exp_stalls); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_collision();
    test_x0();
    test_flush();
    test_ex_ready();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
